// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode map,
// ALU/write-back/PC-source codes and the per-opcode class table.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP,
    ST_HALTED
  } state_t;

  localparam int unsigned OPC_STORE   = 0;
  localparam int unsigned OPC_SETI    = 1;
  localparam int unsigned OPC_LOAD    = 2;
  localparam int unsigned OPC_COMPARE = 3;
  localparam int unsigned OPC_JUMP    = 4;
  localparam int unsigned OPC_INC     = 5;
  localparam int unsigned OPC_BRANCH  = 6;
  localparam int unsigned OPC_STOREI  = 7;
  localparam int unsigned OPC_RSV8    = 8;
  localparam int unsigned OPC_RSV9    = 9;
  localparam int unsigned OPC_RSV10   = 10;
  localparam int unsigned OPC_RSV11   = 11;
  localparam int unsigned OPC_RSV12   = 12;
  localparam int unsigned OPC_RSV13   = 13;
  localparam int unsigned OPC_RSV14   = 14;
  localparam int unsigned OPC_HALT    = 15;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_CMP  = 2;
  localparam int ALU_PASS = 3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam logic [1:0] WB_PC1 = 2'd3;

  localparam logic [1:0] PC_NEXT   = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_REG    = 2'd2;
  localparam logic [1:0] PC_TRAP   = 2'd3;

  typedef struct packed {
    logic rd1;
    logic rd2;
    logic writes;
    logic mem;
    logic mem_we;
    logic branch;
    logic jump;
    logic illegal;
    logic halt;
  } op_class_t;

  // Anything not listed (the reserved block) classifies as illegal.
  function automatic op_class_t class_of(input int unsigned opc);
    op_class_t c;
    c = '0;
    case (opc)
      OPC_STORE:   begin c.rd1 = 1'b1; c.rd2 = 1'b1; c.mem = 1'b1; c.mem_we = 1'b1; end
      OPC_SETI:    c.writes = 1'b1;
      OPC_LOAD:    begin c.rd1 = 1'b1; c.writes = 1'b1; c.mem = 1'b1; end
      OPC_COMPARE: begin c.rd1 = 1'b1; c.rd2 = 1'b1; c.writes = 1'b1; end
      OPC_JUMP:    begin c.rd1 = 1'b1; c.jump = 1'b1; end
      OPC_INC:     begin c.rd1 = 1'b1; c.writes = 1'b1; end
      OPC_BRANCH:  begin c.rd1 = 1'b1; c.rd2 = 1'b1; c.branch = 1'b1; end
      OPC_STOREI:  begin c.rd1 = 1'b1; c.mem = 1'b1; c.mem_we = 1'b1; end
      OPC_HALT:    c.halt = 1'b1;
      default:     c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/op_classify.sv
// Combinational opcode/function decode into class flags, ALU op,
// write-back source and jump target select.
module op_classify #(
  parameter int OPC_W   = 4,
  parameter int FUNC_W  = 5,
  parameter int ALUOP_W = 3
) (
  input  logic [OPC_W-1:0]   i_opc,
  input  logic [FUNC_W-1:0]  i_func,
  output logic               o_rd1,
  output logic               o_rd2,
  output logic               o_writes,
  output logic               o_mem,
  output logic               o_mem_we,
  output logic               o_branch,
  output logic               o_jump_load,
  output logic [1:0]         o_jump_sel,
  output logic               o_illegal,
  output logic               o_halt,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic [1:0]         o_wb_sel
);
  import ctrl_pkg::*;

  op_class_t w_cls;
  logic      w_func_zero;

  always_comb begin
    w_cls       = class_of(32'(i_opc));
    w_func_zero = (i_func == '0);

    o_rd1       = w_cls.rd1;
    o_rd2       = w_cls.rd2;
    o_mem       = w_cls.mem;
    o_mem_we    = w_cls.mem_we;
    o_branch    = w_cls.branch;
    o_illegal   = w_cls.illegal;
    o_halt      = w_cls.halt;
    // Jump func 0 is the link form: it writes PC+1 instead of redirecting.
    o_writes    = w_cls.writes | (w_cls.jump & w_func_zero);
    o_jump_load = w_cls.jump & ((i_func == FUNC_W'(1)) | (i_func == FUNC_W'(2)));
    o_jump_sel  = (i_func == FUNC_W'(2)) ? PC_REG : PC_BRANCH;

    o_alu_op = ALUOP_W'(ALU_ADD);
    o_wb_sel = WB_ALU;
    case (32'(i_opc))
      OPC_SETI:    begin o_alu_op = ALUOP_W'(ALU_PASS); o_wb_sel = WB_IMM; end
      OPC_LOAD:    o_wb_sel = WB_MEM;
      OPC_COMPARE: o_alu_op = ALUOP_W'(ALU_CMP);
      OPC_JUMP:    begin o_alu_op = ALUOP_W'(ALU_PASS); o_wb_sel = WB_PC1; end
      OPC_INC:     o_alu_op = w_func_zero ? ALUOP_W'(ALU_ADD) : ALUOP_W'(ALU_SUB);
      OPC_BRANCH:  o_alu_op = ALUOP_W'(ALU_SUB);
      default:     ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshake and timeout, illegal-opcode trap, HALT and retired counter.
module multicycle_control #(
  parameter int INSTR_W     = 10,
  parameter int OPC_W       = 4,
  parameter int FUNC_W      = 5,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_instr_valid,
  input  logic [INSTR_W-1:0]  i_instr,
  output logic                o_instr_ready,
  input  logic                i_alu_zero,
  input  logic                i_mem_ack,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic                o_reg_rd1_en,
  output logic                o_reg_rd2_en,
  output logic                o_reg_we,
  output logic [1:0]          o_wb_sel,
  output logic [ALUOP_W-1:0]  o_alu_op,
  output logic                o_pc_load,
  output logic [1:0]          o_pc_sel,
  output logic                o_trap,
  output logic                o_halted,
  output logic [RETIRE_W-1:0] o_retired
);
  import ctrl_pkg::*;

  localparam int              CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [OPC_W-1:0]     r_opc;
  logic [FUNC_W-1:0]    r_func;
  logic [OPC_W-1:0]     w_opc;
  logic [FUNC_W-1:0]    w_func;
  logic [CNT_W-1:0]     r_cnt;
  logic [RETIRE_W-1:0]  r_retired;
  logic                 r_mem_req, r_mem_we, r_rd1_en, r_rd2_en, r_reg_we;
  logic                 r_trap, r_halted;
  logic [1:0]           r_wb_sel;
  logic [ALUOP_W-1:0]   r_alu_op;
  logic                 w_pc_load;
  logic [1:0]           w_pc_sel;
  logic                 w_retire;
  logic                 w_unused_lsb;

  logic                 w_rd1, w_rd2, w_writes, w_mem, w_mem_we, w_branch;
  logic                 w_jump_load, w_illegal, w_halt;
  logic [1:0]           w_jump_sel, w_wb_sel;
  logic [ALUOP_W-1:0]   w_alu_op;

  // In FETCH the incoming word is classified so DECODE's read enables can
  // be registered; afterwards the latched fields drive the decode.
  assign w_opc        = (r_state == ST_FETCH) ? i_instr[INSTR_W-1 -: OPC_W] : r_opc;
  assign w_func       = (r_state == ST_FETCH) ? i_instr[FUNC_W:1] : r_func;
  assign w_unused_lsb = i_instr[0];

  op_classify #(
    .OPC_W   (OPC_W),
    .FUNC_W  (FUNC_W),
    .ALUOP_W (ALUOP_W)
  ) u_classify (
    .i_opc       (w_opc),
    .i_func      (w_func),
    .o_rd1       (w_rd1),
    .o_rd2       (w_rd2),
    .o_writes    (w_writes),
    .o_mem       (w_mem),
    .o_mem_we    (w_mem_we),
    .o_branch    (w_branch),
    .o_jump_load (w_jump_load),
    .o_jump_sel  (w_jump_sel),
    .o_illegal   (w_illegal),
    .o_halt      (w_halt),
    .o_alu_op    (w_alu_op),
    .o_wb_sel    (w_wb_sel)
  );

  // pc_load is decided in the same cycle as alu_zero / mem_ack arrive, so
  // it is decoded from the registered state rather than registered itself.
  always_comb begin
    w_state_next = r_state;
    w_pc_load    = 1'b0;
    w_pc_sel     = PC_NEXT;
    case (r_state)
      ST_FETCH:  if (i_instr_valid) w_state_next = ST_DECODE;
      ST_DECODE: begin
        if (w_halt)         w_state_next = ST_HALTED;
        else if (w_illegal) w_state_next = ST_TRAP;
        else                w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_mem)         w_state_next = ST_MEM;
        else if (w_writes) w_state_next = ST_WB;
        else begin
          w_state_next = ST_FETCH;
          w_pc_load    = 1'b1;
          if (w_branch && i_alu_zero) w_pc_sel = PC_BRANCH;
          else if (w_jump_load)       w_pc_sel = w_jump_sel;
        end
      end
      ST_MEM: begin
        if (i_mem_ack) begin
          if (w_mem_we) begin
            w_state_next = ST_FETCH;
            w_pc_load    = 1'b1;
          end else begin
            w_state_next = ST_WB;
          end
        end else if (r_cnt == CNT_LIMIT) begin
          w_state_next = ST_TRAP;
        end
      end
      ST_WB: begin
        w_state_next = ST_FETCH;
        w_pc_load    = 1'b1;
      end
      ST_TRAP: begin
        w_state_next = ST_FETCH;
        w_pc_load    = 1'b1;
        w_pc_sel     = PC_TRAP;
      end
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_FETCH;
    endcase
  end

  assign w_retire = (w_state_next == ST_FETCH) &&
                    ((r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_opc     <= '0;
      r_func    <= '0;
      r_cnt     <= '0;
      r_retired <= '0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_rd1_en  <= 1'b0;
      r_rd2_en  <= 1'b0;
      r_reg_we  <= 1'b0;
      r_wb_sel  <= WB_ALU;
      r_alu_op  <= '0;
      r_trap    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_FETCH) && i_instr_valid) begin
        r_opc  <= i_instr[INSTR_W-1 -: OPC_W];
        r_func <= i_instr[FUNC_W:1];
      end
      // Outputs are registered for the state being entered.
      r_rd1_en  <= (w_state_next == ST_DECODE) && w_rd1;
      r_rd2_en  <= (w_state_next == ST_DECODE) && w_rd2;
      r_alu_op  <= (w_state_next == ST_EXEC) ? w_alu_op : '0;
      r_mem_req <= (w_state_next == ST_MEM);
      r_mem_we  <= (w_state_next == ST_MEM) && w_mem_we;
      r_reg_we  <= (w_state_next == ST_WB);
      r_wb_sel  <= (w_state_next == ST_WB) ? w_wb_sel : WB_ALU;
      if ((r_state == ST_MEM) && (w_state_next == ST_MEM)) r_cnt <= r_cnt + 1'b1;
      else                                                 r_cnt <= '0;
      if (w_state_next == ST_TRAP)   r_trap   <= 1'b1;
      if (w_state_next == ST_HALTED) r_halted <= 1'b1;
      if (w_retire)                  r_retired <= r_retired + 1'b1;
    end
  end

  assign o_instr_ready = (r_state == ST_FETCH);
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_reg_rd1_en  = r_rd1_en;
  assign o_reg_rd2_en  = r_rd2_en;
  assign o_reg_we      = r_reg_we;
  assign o_wb_sel      = r_wb_sel;
  assign o_alu_op      = r_alu_op;
  assign o_pc_load     = w_pc_load;
  assign o_pc_sel      = w_pc_sel;
  assign o_trap        = r_trap;
  assign o_halted      = r_halted;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction vector table plus
// hand sequences for reset, timeout, halt and reset during a memory wait.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_instr_valid;
  logic [9:0]  i_instr;
  logic        o_instr_ready;
  logic        i_alu_zero;
  logic        i_mem_ack;
  logic        o_mem_req, o_mem_we, o_reg_rd1_en, o_reg_rd2_en, o_reg_we;
  logic [1:0]  o_wb_sel;
  logic [2:0]  o_alu_op;
  logic        o_pc_load;
  logic [1:0]  o_pc_sel;
  logic        o_trap, o_halted;
  logic [15:0] o_retired;

  int checks = 0;
  int failures = 0;
  int exp_retired = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk           (clk),
    .rst           (rst),
    .i_instr_valid (i_instr_valid),
    .i_instr       (i_instr),
    .o_instr_ready (o_instr_ready),
    .i_alu_zero    (i_alu_zero),
    .i_mem_ack     (i_mem_ack),
    .o_mem_req     (o_mem_req),
    .o_mem_we      (o_mem_we),
    .o_reg_rd1_en  (o_reg_rd1_en),
    .o_reg_rd2_en  (o_reg_rd2_en),
    .o_reg_we      (o_reg_we),
    .o_wb_sel      (o_wb_sel),
    .o_alu_op      (o_alu_op),
    .o_pc_load     (o_pc_load),
    .o_pc_sel      (o_pc_sel),
    .o_trap        (o_trap),
    .o_halted      (o_halted),
    .o_retired     (o_retired)
  );

  typedef struct {
    logic [9:0] ins;
    logic       az;
    int         ack_wait;
    int         lat;
    int         we;
    int         wb;
    int         req;
    int         mwe;
    int         alu;
    int         rd;
    int         pcsel;
    int         ret;
    int         trap;
  } vec_t;

  function automatic vec_t mv(input int opc, input int func, input int az, input int ack,
                              input int lat, input int we, input int wb, input int req,
                              input int mwe, input int alu, input int rd, input int pcsel,
                              input int ret, input int trap);
    vec_t v;
    v.ins = {opc[3:0], func[4:0], 1'b0};
    v.az = az[0]; v.ack_wait = ack; v.lat = lat; v.we = we; v.wb = wb; v.req = req;
    v.mwe = mwe; v.alu = alu; v.rd = rd; v.pcsel = pcsel; v.ret = ret; v.trap = trap;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one instruction from FETCH to its final pc_load, then checks retired/trap.
  task automatic run_vec(input vec_t v, input string tag);
    int  lat = 0, we = 0, wb = 0, req = 0, mwe = 0, alu = 0, rd = 0, pcsel = -1;
    bit  done = 0;
    @(negedge clk);
    i_instr = v.ins; i_instr_valid = 1'b1; i_alu_zero = v.az; i_mem_ack = 1'b0;
    #1;
    chk({tag, ".ready"}, 32'(o_instr_ready), 32'd1);
    for (int c = 1; c <= 40 && !done; c++) begin
      if (c > 1) begin
        @(negedge clk);
        i_instr_valid = 1'b0;
        i_mem_ack = o_mem_req && (req == v.ack_wait);
        #1;
      end
      if (c == 2) rd = int'({o_reg_rd1_en, o_reg_rd2_en});
      if (c == 3) alu = int'(o_alu_op);
      if (o_reg_we) begin we++; wb = int'(o_wb_sel); end
      if (o_mem_req) begin req++; mwe = mwe | int'(o_mem_we); end
      if (o_pc_load) begin pcsel = int'(o_pc_sel); lat = c; done = 1; end
    end
    if (!done) $display("FAIL %s.bound: got no pc_load expected one within 40 cycles", tag);
    chk({tag, ".latency"}, lat, v.lat);
    chk({tag, ".reg_we"}, we, v.we);
    chk({tag, ".wb_sel"}, wb, v.wb);
    chk({tag, ".mem_req_cycles"}, req, v.req);
    chk({tag, ".mem_we"}, mwe, v.mwe);
    chk({tag, ".alu_op"}, alu, v.alu);
    chk({tag, ".rd_en"}, rd, v.rd);
    chk({tag, ".pc_sel"}, pcsel, v.pcsel);
    @(negedge clk);
    i_mem_ack = 1'b0;
    #1;
    exp_retired = (exp_retired + v.ret) & 32'hFFFF;
    chk({tag, ".retired"}, 32'(o_retired), exp_retired);
    chk({tag, ".trap"}, 32'(o_trap), v.trap);
    $display("txn %s ins=%h lat=%0d we=%0d wb=%0d req=%0d pc_sel=%0d retired=%0d trap=%0d",
             tag, v.ins, lat, we, wb, req, pcsel, o_retired, o_trap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_instr_valid = 1'b0; i_mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_retired = 0;
  endtask

  vec_t vecs[14];

  initial begin
    int ready_seen;
    int pcl_seen;
    //            opc fn az ack lat we wb req mwe alu rd pcs ret trap
    vecs[0]  = mv(1, 0, 0, 0,  4, 1, 1, 0,  0, 3, 0, 0, 1, 0);  // SETI
    vecs[1]  = mv(3, 0, 0, 0,  4, 1, 0, 0,  0, 2, 3, 0, 1, 0);  // COMPARE
    vecs[2]  = mv(5, 0, 0, 0,  4, 1, 0, 0,  0, 0, 2, 0, 1, 0);  // INC add
    vecs[3]  = mv(5, 3, 0, 0,  4, 1, 0, 0,  0, 1, 2, 0, 1, 0);  // INC sub
    vecs[4]  = mv(2, 0, 0, 3,  8, 1, 2, 4,  0, 0, 2, 0, 1, 0);  // LOAD, 3 wait
    vecs[5]  = mv(0, 0, 0, 2,  6, 0, 0, 3,  1, 0, 3, 0, 1, 0);  // STORE, 2 wait
    vecs[6]  = mv(7, 0, 0, 0,  4, 0, 0, 1,  1, 0, 2, 0, 1, 0);  // STOREI, no wait
    vecs[7]  = mv(6, 0, 1, 0,  3, 0, 0, 0,  0, 1, 3, 1, 1, 0);  // BRANCH taken
    vecs[8]  = mv(6, 0, 0, 0,  3, 0, 0, 0,  0, 1, 3, 0, 1, 0);  // BRANCH not taken
    vecs[9]  = mv(4, 1, 0, 0,  3, 0, 0, 0,  0, 3, 2, 1, 1, 0);  // JUMP target
    vecs[10] = mv(4, 2, 0, 0,  3, 0, 0, 0,  0, 3, 2, 2, 1, 0);  // JUMP register
    vecs[11] = mv(4, 0, 0, 0,  4, 1, 3, 0,  0, 3, 2, 0, 1, 0);  // JUMP link
    vecs[12] = mv(7, 0, 0, 14, 18, 0, 0, 15, 1, 0, 2, 0, 1, 0); // ack on limit cycle
    vecs[13] = mv(9, 0, 0, 0,  3, 0, 0, 0,  0, 0, 0, 3, 0, 1);  // reserved opcode

    rst = 1'b1; i_instr_valid = 1'b0; i_instr = '0; i_alu_zero = 1'b0; i_mem_ack = 1'b0;
    do_reset();
    chk("reset.ready", 32'(o_instr_ready), 32'd1);
    chk("reset.mem_req", 32'(o_mem_req), 32'd0);
    chk("reset.reg_we", 32'(o_reg_we), 32'd0);
    chk("reset.pc_load", 32'(o_pc_load), 32'd0);
    chk("reset.alu_op", 32'(o_alu_op), 32'd0);
    chk("reset.trap", 32'(o_trap), 32'd0);
    chk("reset.halted", 32'(o_halted), 32'd0);
    chk("reset.retired", 32'(o_retired), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // HALT: absorbing, fetch stays closed until reset.
    @(negedge clk);
    i_instr = {4'd15, 5'd0, 1'b0}; i_instr_valid = 1'b1;
    ready_seen = 0; pcl_seen = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      i_instr_valid = 1'b1;
      #1;
      if (o_instr_ready) ready_seen++;
      if (o_pc_load || o_mem_req || o_reg_we) pcl_seen++;
    end
    chk("halt.ready_cycles", ready_seen, 0);
    chk("halt.strobes", pcl_seen, 0);
    chk("halt.halted", 32'(o_halted), 32'd1);
    chk("halt.retired", 32'(o_retired), exp_retired);
    $display("txn halt halted=%0d ready_cycles=%0d", o_halted, ready_seen);
    do_reset();
    chk("halt_rst.halted", 32'(o_halted), 32'd0);
    chk("halt_rst.trap", 32'(o_trap), 32'd0);
    chk("halt_rst.ready", 32'(o_instr_ready), 32'd1);

    // Memory timeout traps without retiring; the next instruction still runs.
    run_vec(mv(0, 0, 0, 99, 19, 0, 0, 15, 1, 0, 3, 3, 0, 1), "timeout");
    run_vec(mv(1, 0, 0, 0, 4, 1, 1, 0, 0, 3, 0, 0, 1, 1), "after_timeout");

    // Reset while a store waits for its ack.
    @(negedge clk);
    i_instr = {4'd7, 5'd0, 1'b0}; i_instr_valid = 1'b1; i_mem_ack = 1'b0;
    @(negedge clk);
    i_instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("midmem.req_before", 32'(o_mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midmem.req_after", 32'(o_mem_req), 32'd0);
    chk("midmem.ready", 32'(o_instr_ready), 32'd1);
    chk("midmem.reg_we", 32'(o_reg_we), 32'd0);
    chk("midmem.retired", 32'(o_retired), 32'd0);
    $display("txn midmem_reset mem_req=%0d ready=%0d retired=%0d", o_mem_req, o_instr_ready, o_retired);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
